// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-side hazard / flush controller.
// Tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB) and
// compares them with the sources of the instruction in ID. It produces the
// PC / IF-ID stall controls, the IF-ID and ID-EX flushes, a sticky halt
// status and a saturating data-hazard stall counter.
// Optional build macro: HAZARD_CTRL_FORWARD_EN -- the EX stage forwards from
// EX/MEM and MEM/WB, so only a load-use on the EX entry stalls (1 bubble).
module hazard_ctrl #(
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_vld,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_vld,
    input  logic [2:0]       id_wr_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // One in-flight producer: valid write, destination register, is a load
    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    sb_entry_t sb_ex_next;
    state_t    state;

    logic match_ex;
    logic match_mem;
    logic match_wb;
    logic hazard_c;
    logic stall_c;
    logic flush_if_c;
    logic flush_ex_c;
    logic cnt_inc_c;

    // True when the ID instruction really reads the entry's destination register
    function automatic logic sb_match(
        input sb_entry_t        e,
        input logic             valid,
        input logic [REG_W-1:0] rs,
        input logic             rs_vld,
        input logic [REG_W-1:0] rt,
        input logic             rt_vld
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = rs_vld && (rs == e.rd);
        rt_hit = rt_vld && (rt == e.rd);
        return valid && e.vld && (rs_hit || rt_hit);
    endfunction

    // Source/destination comparison against every scoreboard stage
    always_comb begin
        match_ex  = sb_match(sb_ex,  id_valid, id_rs, id_rs_vld, id_rt, id_rt_vld);
        match_mem = sb_match(sb_mem, id_valid, id_rs, id_rs_vld, id_rt, id_rt_vld);
        match_wb  = sb_match(sb_wb,  id_valid, id_rs, id_rs_vld, id_rt, id_rt_vld);
    end

`ifdef HAZARD_CTRL_FORWARD_EN
    // Forwarding covers ALU results; only a load still in EX must wait
    assign hazard_c = match_ex && sb_ex.ld;

    logic unused_bits;
    assign unused_bits = ^{sb_wb.ld, match_mem, match_wb, WB_BYPASS};
`else
    // Full interlock: wait until the producer has written the register file
    assign hazard_c = match_ex || match_mem || (!WB_BYPASS && match_wb);

    logic unused_bits;
    assign unused_bits = sb_wb.ld;
`endif

    // Pipeline action select: halted > ex_halt > ex_redirect > hazard
    always_comb begin
        stall_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_ex_c = 1'b0;
        cnt_inc_c  = 1'b0;
        if (state == ST_HALT) begin
            stall_c    = 1'b1;
            flush_ex_c = 1'b1;
        end else if (ex_halt || ex_redirect) begin
            flush_if_c = 1'b1;
            flush_ex_c = 1'b1;
        end else if (hazard_c) begin
            stall_c    = 1'b1;
            flush_ex_c = 1'b1;
            cnt_inc_c  = 1'b1;
        end
    end

    // Controls are combinational and forced low while reset is held
    assign stall_pc    = rst & stall_c;
    assign stall_if_id = rst & stall_c;
    assign flush_if_id = rst & flush_if_c;
    assign flush_id_ex = rst & flush_ex_c;
    assign halted      = (state == ST_HALT);

    // Entry for the instruction leaving ID; a flushed slot becomes a bubble
    always_comb begin
        sb_ex_next     = '0;
        if (!flush_ex_c) begin
            sb_ex_next.vld = id_valid & id_reg_write;
            sb_ex_next.rd  = id_wr_reg;
            sb_ex_next.ld  = id_mem_read;
        end
    end

    // Scoreboard shifts every cycle alongside the pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= sb_ex_next;
        end
    end

    // Halt latch: entered on ex_halt, left only through reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (ex_halt) state <= ST_HALT;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of data-hazard stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_inc_c && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized bench for hazard_ctrl.
// Two instances share the stimulus: A (WB_BYPASS=1, CNT_W=16) and
// B (WB_BYPASS=0, CNT_W=2). Each is compared every cycle with a reference
// model that keeps a history of the last three instructions that left ID.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int NM = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs = 3'd0;
    logic       id_rs_vld = 1'b0;
    logic [2:0] id_rt = 3'd0;
    logic       id_rt_vld = 1'b0;
    logic [2:0] id_wr_reg = 3'd0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       ex_halt = 1'b0;

    logic        sp_a, si_a, fi_a, fe_a, h_a;
    logic [15:0] cnt_a;
    logic        sp_b, si_b, fi_b, fe_b, h_b;
    logic [1:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_vld(id_rs_vld),
        .id_rt(id_rt), .id_rt_vld(id_rt_vld), .id_wr_reg(id_wr_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .stall_pc(sp_a), .stall_if_id(si_a), .flush_if_id(fi_a), .flush_id_ex(fe_a),
        .halted(h_a), .stall_cnt(cnt_a)
    );

    hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_vld(id_rs_vld),
        .id_rt(id_rt), .id_rt_vld(id_rt_vld), .id_wr_reg(id_wr_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .stall_pc(sp_b), .stall_if_id(si_b), .flush_if_id(fi_b), .flush_id_ex(fe_b),
        .halted(h_b), .stall_cnt(cnt_b)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       vld;
        logic [2:0] rd;
        logic       ld;
    } prod_t;

    typedef struct packed {
        logic sp;
        logic si;
        logic fi;
        logic fe;
        logic inc;
    } exp_t;

    // Per-model configuration: register-file bypass and counter ceiling
    bit    wbb  [NM] = '{1'b1, 1'b0};
    int    cmax [NM] = '{65535, 3};
    prod_t hist [NM][3];          // [0] = newest instruction that left ID
    bit    m_halted [NM];
    int    m_cnt    [NM];

    function automatic bit reads_reg(input logic [2:0] r);
        return id_valid && ((id_rs_vld && id_rs == r) || (id_rt_vld && id_rt == r));
    endfunction

    // A producer blocks ID until its value is usable
    function automatic bit model_hazard(input int m);
        int depth;
        if (FWD)
            return hist[m][0].vld && hist[m][0].ld && reads_reg(hist[m][0].rd);
        depth = wbb[m] ? 2 : 3;
        for (int k = 0; k < depth; k++)
            if (hist[m][k].vld && reads_reg(hist[m][k].rd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model_outs(input int m);
        exp_t e;
        e = '0;
        if (rst !== 1'b1) return e;
        if (m_halted[m]) begin
            e.sp = 1; e.si = 1; e.fe = 1;
        end else if (ex_halt || ex_redirect) begin
            e.fi = 1; e.fe = 1;
        end else if (model_hazard(m)) begin
            e.sp = 1; e.si = 1; e.fe = 1; e.inc = 1;
        end
        return e;
    endfunction

    task automatic model_clock(input int m, input exp_t e);
        prod_t n;
        n = '0;
        if (!e.fe) n = '{vld: id_valid & id_reg_write, rd: id_wr_reg, ld: id_mem_read};
        hist[m][2] = hist[m][1];
        hist[m][1] = hist[m][0];
        hist[m][0] = n;
        if (ex_halt) m_halted[m] = 1'b1;
        if (e.inc && m_cnt[m] < cmax[m]) m_cnt[m]++;
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int k = 0; k < 3; k++) hist[m][k] = '0;
            m_halted[m] = 1'b0;
            m_cnt[m]    = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        exp_t ea, eb;
        ea = model_outs(0);
        eb = model_outs(1);
        check({ph, ".a.stall_pc"},    32'(sp_a),  32'(ea.sp));
        check({ph, ".a.stall_if_id"}, 32'(si_a),  32'(ea.si));
        check({ph, ".a.flush_if_id"}, 32'(fi_a),  32'(ea.fi));
        check({ph, ".a.flush_id_ex"}, 32'(fe_a),  32'(ea.fe));
        check({ph, ".a.halted"},      32'(h_a),   32'(m_halted[0]));
        check({ph, ".a.stall_cnt"},   32'(cnt_a), 32'(m_cnt[0]));
        check({ph, ".b.stall_pc"},    32'(sp_b),  32'(eb.sp));
        check({ph, ".b.stall_if_id"}, 32'(si_b),  32'(eb.si));
        check({ph, ".b.flush_if_id"}, 32'(fi_b),  32'(eb.fi));
        check({ph, ".b.flush_id_ex"}, 32'(fe_b),  32'(eb.fe));
        check({ph, ".b.halted"},      32'(h_b),   32'(m_halted[1]));
        check({ph, ".b.stall_cnt"},   32'(cnt_b), 32'(m_cnt[1]));
    endtask

    // One clock: called at a negedge with inputs set; returns at the next negedge
    task automatic step(input string ph);
        exp_t e [NM];
        #2;
        check_all(ph);
        for (int m = 0; m < NM; m++) e[m] = model_outs(m);
        @(posedge clk);
        for (int m = 0; m < NM; m++) model_clock(m, e[m]);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, released on the next negedge
    task automatic do_reset(input string ph);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all(ph);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic rsv,
                          input logic [2:0] rt, input logic rtv,
                          input logic [2:0] wr, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rs_vld = rsv; id_rt = rt; id_rt_vld = rtv;
        id_wr_reg = wr; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic rand_id();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_rs        = 3'($urandom_range(0, 7));
        id_rs_vld    = ($urandom_range(0, 3) != 0);
        id_rt        = 3'($urandom_range(0, 7));
        id_rt_vld    = ($urandom_range(0, 1) != 0);
        id_wr_reg    = 3'($urandom_range(0, 7));
        id_reg_write = ($urandom_range(0, 2) != 0);
        id_mem_read  = id_reg_write && ($urandom_range(0, 2) == 0);
        ex_redirect  = ($urandom_range(0, 9) == 0);
    endtask

    task automatic bubble();
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        ex_redirect = 1'b0;
        ex_halt     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1 rst = 1'b0;
        rand_id();
        ex_halt = 1'b1;
        #1 check_all("reset");
        @(negedge clk);
        bubble();
        rst = 1'b1;

        // ALU producer of r3 followed by a reader of r3 held in ID
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        step("t1.prod");
        set_id(1'b1, 3'd3, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t1.use");
        bubble();
        #1;
        check("t1.cnt_a", 32'(cnt_a), FWD ? 32'd0 : 32'd2);
        check("t1.cnt_b", 32'(cnt_b), FWD ? 32'd0 : 32'd3);
        for (int i = 0; i < 3; i++) step("t1.drain");

        // Redirect in EX overrides a hazard on r1
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
        step("t3.prod");
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        ex_redirect = 1'b1;
        #1;
        check("t3.stall_pc", 32'(sp_a), 32'd0);
        check("t3.flush_if_id", 32'(fi_a), 32'd1);
        step("t3.redir");
        bubble();
        for (int i = 0; i < 3; i++) step("t3.drain");

        // Non-reading or invalid ID instruction must not stall; WB entry only stalls B
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        step("t5.prod");
        set_id(1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
        #1 check("t5.invalid.stall_pc", 32'(sp_a), 32'd0);
        step("t5.invalid");
        set_id(1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0);
        #1 check("t5.novld.stall_pc", 32'(sp_a), 32'd0);
        step("t5.novld");
        set_id(1'b1, 3'd2, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
        #1;
        check("t5.wb.a.stall_pc", 32'(sp_a), 32'd0);
        check("t5.wb.b.stall_pc", 32'(sp_b), FWD ? 32'd0 : 32'd1);
        step("t5.wb");
        bubble();
        for (int i = 0; i < 3; i++) step("t5.drain");

        // r0 is an ordinary register
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        step("r0.prod");
        set_id(1'b1, 3'd0, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0);
        #1 check("r0.stall_pc", 32'(sp_a), FWD ? 32'd0 : 32'd1);
        step("r0.use");
        bubble();
        for (int i = 0; i < 3; i++) step("r0.drain");

        // Load-use on r2 via rt
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        step("ld.prod");
        set_id(1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
        #1 check("ld.stall_pc", 32'(sp_a), 32'd1);
        for (int i = 0; i < 3; i++) step("ld.use");
        bubble();
        for (int i = 0; i < 3; i++) step("ld.drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            step("rand1");
        end

        // Reset in the middle of a stall; scoreboard must come back empty
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        ex_redirect = 1'b0;
        step("mrst.prod");
        set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1 check("mrst.pre.stall_pc", 32'(sp_a), FWD ? 32'd0 : 32'd1);
        do_reset("mrst.inreset");
        #1 check("mrst.post.stall_pc", 32'(sp_a), 32'd0);
        step("mrst.post");

        // Halt: sticky freeze, then reset releases it
        for (int i = 0; i < 20; i++) begin
            rand_id();
            step("rand2");
        end
        rand_id();
        ex_redirect = 1'b0;
        ex_halt     = 1'b1;
        #1 check("halt.flush_if_id", 32'(fi_a), 32'd1);
        step("halt.pulse");
        ex_halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rand_id();
            ex_halt = ($urandom_range(0, 3) == 0);
            step("halted");
        end
        #1;
        check("halt.stall_pc", 32'(sp_a), 32'd1);
        check("halt.halted",   32'(h_a),  32'd1);
        do_reset("halt.rst");
        ex_halt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rand_id();
            step("rand3");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
